// File: rtl/seg7_pkg.sv
// Shared definitions for the 4-digit 7-segment output path: segment patterns,
// converter FSM encoding and the display range limit.
package seg7_pkg;

    localparam int unsigned BIN_W = 14;
    localparam int unsigned BCD_W = 16;
    localparam int unsigned MAX_DISPLAY = 9999;

    // Active-low patterns, bit 0 = segment a, bit 7 = dp (always off).
    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_DASH  = 8'hBF;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StShift = 2'd1,
        StDone  = 2'd2
    } conv_state_e;

    function automatic logic [7:0] seg_decode(input logic [3:0] nib);
        logic [7:0] pat;
        case (nib)
            4'd0:    pat = SEG_0;
            4'd1:    pat = SEG_1;
            4'd2:    pat = SEG_2;
            4'd3:    pat = SEG_3;
            4'd4:    pat = SEG_4;
            4'd5:    pat = SEG_5;
            4'd6:    pat = SEG_6;
            4'd7:    pat = SEG_7;
            4'd8:    pat = SEG_8;
            4'd9:    pat = SEG_9;
            default: pat = SEG_BLANK;
        endcase
        return pat;
    endfunction

    // Double-dabble correction: each nibble >= 5 gets +3, wrapping within the nibble.
    function automatic logic [BCD_W-1:0] bcd_adjust(input logic [BCD_W-1:0] v);
        logic [BCD_W-1:0] r;
        for (int i = 0; i < 4; i++) begin
            r[i*4 +: 4] = (v[i*4 +: 4] >= 4'd5) ? v[i*4 +: 4] + 4'd3 : v[i*4 +: 4];
        end
        return r;
    endfunction

endpackage

// File: rtl/seg7_scan_display_bin2bcd_seq.sv
// Sequential binary-to-BCD converter, one bit per cycle. Results are committed
// atomically in the DONE state so partial BCD never reaches the outputs.
module bin2bcd_seq
    import seg7_pkg::*;
(
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic [BIN_W-1:0] bin_in,
    input  logic             start,
    output logic [BCD_W-1:0] bcd,
    output logic             ovf,
    output logic             done,
    output logic             busy
);

    localparam logic [3:0]       LastIter = 4'(BIN_W - 1);
    localparam logic [BIN_W-1:0] MaxDisp  = BIN_W'(MAX_DISPLAY);

    conv_state_e      state_q, state_d;
    logic [BIN_W-1:0] shift_q, shift_d;
    logic [BCD_W-1:0] acc_q, acc_d;
    logic [3:0]       iter_q, iter_d;
    logic             ovf_pend_q, ovf_pend_d;
    logic [BCD_W-1:0] bcd_q, bcd_d;
    logic             ovf_q, ovf_d;
    logic [BCD_W-1:0] acc_adj;

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        acc_d      = acc_q;
        iter_d     = iter_q;
        ovf_pend_d = ovf_pend_q;
        bcd_d      = bcd_q;
        ovf_d      = ovf_q;
        done       = 1'b0;
        acc_adj    = bcd_adjust(acc_q);

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    shift_d    = bin_in;
                    acc_d      = '0;
                    iter_d     = '0;
                    ovf_pend_d = (bin_in > MaxDisp);
                    state_d    = StShift;
                end
            end
            StShift: begin
                acc_d   = {acc_adj[BCD_W-2:0], shift_q[BIN_W-1]};
                shift_d = {shift_q[BIN_W-2:0], 1'b0};
                if (iter_q == LastIter) begin
                    state_d = StDone;
                end else begin
                    iter_d = iter_q + 4'd1;
                end
            end
            StDone: begin
                done  = 1'b1;
                ovf_d = ovf_pend_q;
                // Out-of-range values leave the last good BCD in place.
                if (!ovf_pend_q) begin
                    bcd_d = acc_q;
                end
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q    <= StIdle;
            shift_q    <= '0;
            acc_q      <= '0;
            iter_q     <= '0;
            ovf_pend_q <= 1'b0;
            bcd_q      <= '0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            acc_q      <= acc_d;
            iter_q     <= iter_d;
            ovf_pend_q <= ovf_pend_d;
            bcd_q      <= bcd_d;
            ovf_q      <= ovf_d;
        end
    end

    assign bcd  = bcd_q;
    assign ovf  = ovf_q;
    assign busy = (state_q == StShift);

endmodule

// File: rtl/seg7_scan_display.sv
// 4-digit multiplexed common-anode display driver: change detect, sequential
// BCD conversion, leading-zero blanking and digit scan.
module seg7_scan_display
    import seg7_pkg::*;
#(
    parameter int unsigned SCAN_PERIOD   = 100_000,
    parameter bit          BLANK_LEADING = 1'b1
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic [BIN_W-1:0] bin_data,
    output logic [7:0]       seg,
    output logic [3:0]       dig_sel,
    output logic [BCD_W-1:0] bcd_out,
    output logic             ovf,
    output logic             busy
);

    localparam int unsigned     CntW    = (SCAN_PERIOD > 1) ? $clog2(SCAN_PERIOD) : 1;
    localparam logic [CntW-1:0] ScanMax = CntW'(SCAN_PERIOD - 1);

    logic [BIN_W-1:0] last_val_q, last_val_d;
    logic             start;
    logic             conv_busy;
    logic             conv_done;

    logic [CntW-1:0]  scan_cnt_q, scan_cnt_d;
    logic [1:0]       digit_idx_q, digit_idx_d;
    logic [7:0]       seg_q, seg_d;
    logic [3:0]       dig_sel_q, dig_sel_d;
    logic             wrap;
    logic [3:0]       blank;
    logic [3:0][7:0]  digit_pat;

    // busy covers the commit cycle too, so a new start is only taken from IDLE.
    assign busy  = conv_busy | conv_done;
    assign start = (bin_data != last_val_q) && !busy;

    always_comb begin
        last_val_d = last_val_q;
        if (start) begin
            last_val_d = bin_data;
        end
    end

    bin2bcd_seq u_bin2bcd (
        .sys_clk  (sys_clk),
        .sys_rst_n(sys_rst_n),
        .bin_in   (bin_data),
        .start    (start),
        .bcd      (bcd_out),
        .ovf      (ovf),
        .done     (conv_done),
        .busy     (conv_busy)
    );

    always_comb begin
        blank    = 4'b0000;
        blank[1] = (bcd_out[15:4] == 12'd0);
        blank[2] = (bcd_out[15:8] == 8'd0);
        blank[3] = (bcd_out[15:12] == 4'd0);
        if (!BLANK_LEADING) begin
            blank = 4'b0000;
        end
        for (int i = 0; i < 4; i++) begin
            if (ovf) begin
                digit_pat[i] = SEG_DASH;
            end else if (blank[i]) begin
                digit_pat[i] = SEG_BLANK;
            end else begin
                digit_pat[i] = seg_decode(bcd_out[i*4 +: 4]);
            end
        end
    end

    assign wrap = (scan_cnt_q == ScanMax);

    always_comb begin
        scan_cnt_d  = scan_cnt_q + 1'b1;
        digit_idx_d = digit_idx_q;
        seg_d       = seg_q;
        dig_sel_d   = dig_sel_q;
        // Outputs load the slot being left, so the first wrap shows digit 0.
        if (wrap) begin
            scan_cnt_d  = '0;
            digit_idx_d = digit_idx_q + 2'd1;
            seg_d       = digit_pat[digit_idx_q];
            dig_sel_d   = ~(4'b0001 << digit_idx_q);
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            last_val_q  <= '0;
            scan_cnt_q  <= '0;
            digit_idx_q <= '0;
            seg_q       <= SEG_BLANK;
            dig_sel_q   <= 4'b1111;
        end else begin
            last_val_q  <= last_val_d;
            scan_cnt_q  <= scan_cnt_d;
            digit_idx_q <= digit_idx_d;
            seg_q       <= seg_d;
            dig_sel_q   <= dig_sel_d;
        end
    end

    assign seg     = seg_q;
    assign dig_sel = dig_sel_q;

endmodule

// File: tb/tb_seg7_scan_display.sv
// Directed bench for seg7_scan_display: table of values with expected BCD and
// per-digit patterns, plus hand sequences for scan start, re-trigger and reset.
module tb_seg7_scan_display;

    localparam int unsigned P = 8;

    logic        sys_clk;
    logic        sys_rst_n;
    logic [13:0] bin_data;
    logic [7:0]  seg;
    logic [3:0]  dig_sel;
    logic [15:0] bcd_out;
    logic        ovf;
    logic        busy;

    int n_pass;
    int n_total;

    typedef struct {
        logic [13:0] bin;
        logic [15:0] bcd;
        logic        ovf;
        logic [7:0]  s0;
        logic [7:0]  s1;
        logic [7:0]  s2;
        logic [7:0]  s3;
    } vec_t;

    vec_t vecs[9];

    seg7_scan_display #(
        .SCAN_PERIOD  (P),
        .BLANK_LEADING(1'b1)
    ) dut (
        .sys_clk  (sys_clk),
        .sys_rst_n(sys_rst_n),
        .bin_data (bin_data),
        .seg      (seg),
        .dig_sel  (dig_sel),
        .bcd_out  (bcd_out),
        .ovf      (ovf),
        .busy     (busy)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        @(negedge sys_clk);
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic check_digits(input string tag, input logic [7:0] s0, input logic [7:0] s1,
                                input logic [7:0] s2, input logic [7:0] s3);
        logic [7:0] exp_s [4];
        logic [3:0] tgt;
        int         guard;
        exp_s[0] = s0;
        exp_s[1] = s1;
        exp_s[2] = s2;
        exp_s[3] = s3;
        for (int i = 0; i < 4; i++) begin
            tgt   = ~(4'b0001 << i);
            guard = 0;
            while (dig_sel !== tgt && guard < 6 * P) begin
                tick();
                guard++;
            end
            if (dig_sel !== tgt) begin
                chk($sformatf("%s dig%0d select timeout", tag, i), 32'(dig_sel), 32'(tgt));
            end else begin
                chk($sformatf("%s dig%0d seg", tag, i), 32'(seg), 32'(exp_s[i]));
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, " seg"}, 32'(seg), 32'h0000_00FF);
        chk({tag, " dig_sel"}, 32'(dig_sel), 32'h0000_000F);
        chk({tag, " bcd_out"}, 32'(bcd_out), 32'h0);
        chk({tag, " ovf"}, 32'(ovf), 32'h0);
        chk({tag, " busy"}, 32'(busy), 32'h0);
    endtask

    initial begin
        logic [15:0] prev_bcd;
        logic [15:0] exp_bcd;
        logic        exp_busy;

        n_pass  = 0;
        n_total = 0;

        vecs[0] = '{14'd1234,  16'h1234, 1'b0, 8'h99, 8'hB0, 8'hA4, 8'hF9};
        vecs[1] = '{14'd7,     16'h0007, 1'b0, 8'hF8, 8'hFF, 8'hFF, 8'hFF};
        vecs[2] = '{14'd9999,  16'h9999, 1'b0, 8'h90, 8'h90, 8'h90, 8'h90};
        vecs[3] = '{14'd1005,  16'h1005, 1'b0, 8'h92, 8'hC0, 8'hC0, 8'hF9};
        vecs[4] = '{14'd10000, 16'h1005, 1'b1, 8'hBF, 8'hBF, 8'hBF, 8'hBF};
        vecs[5] = '{14'd42,    16'h0042, 1'b0, 8'hA4, 8'h99, 8'hFF, 8'hFF};
        vecs[6] = '{14'd16383, 16'h0042, 1'b1, 8'hBF, 8'hBF, 8'hBF, 8'hBF};
        vecs[7] = '{14'd100,   16'h0100, 1'b0, 8'hC0, 8'hC0, 8'hF9, 8'hFF};
        vecs[8] = '{14'd0,     16'h0000, 1'b0, 8'hC0, 8'hFF, 8'hFF, 8'hFF};

        // Reset and first scan wrap with value 0.
        sys_rst_n = 1'b0;
        bin_data  = 14'd0;
        repeat (3) @(negedge sys_clk);
        check_reset_outputs("in reset");
        sys_rst_n = 1'b1;
        ticks(P - 1);
        chk("pre-wrap dig_sel", 32'(dig_sel), 32'h0000_000F);
        chk("pre-wrap seg", 32'(seg), 32'h0000_00FF);
        chk("pre-wrap busy", 32'(busy), 32'h0);
        tick();
        chk("wrap1 dig_sel", 32'(dig_sel), 32'h0000_000E);
        chk("wrap1 seg", 32'(seg), 32'h0000_00C0);
        ticks(P);
        chk("wrap2 dig_sel", 32'(dig_sel), 32'h0000_000D);
        chk("wrap2 seg", 32'(seg), 32'h0000_00FF);
        check_digits("zero", 8'hC0, 8'hFF, 8'hFF, 8'hFF);

        // Table-driven values: latency, commit and displayed digits.
        prev_bcd = 16'h0000;
        for (int v = 0; v < 9; v++) begin
            bin_data = vecs[v].bin;
            tick();
            chk($sformatf("v%0d busy N+1", v), 32'(busy), 32'h1);
            ticks(14);
            chk($sformatf("v%0d busy N+15", v), 32'(busy), 32'h1);
            chk($sformatf("v%0d bcd N+15", v), 32'(bcd_out), 32'(prev_bcd));
            tick();
            chk($sformatf("v%0d bcd", v), 32'(bcd_out), 32'(vecs[v].bcd));
            chk($sformatf("v%0d ovf", v), 32'(ovf), 32'(vecs[v].ovf));
            chk($sformatf("v%0d busy N+16", v), 32'(busy), 32'h0);
            ticks(4 * P + 2);
            check_digits($sformatf("v%0d", v), vecs[v].s0, vecs[v].s1, vecs[v].s2, vecs[v].s3);
            prev_bcd = vecs[v].bcd;
        end

        // Change during conversion: 56 commits, then 789 is picked up from IDLE.
        bin_data = 14'd56;
        for (int c = 1; c <= 32; c++) begin
            tick();
            exp_busy = ((c >= 1 && c <= 15) || (c >= 17 && c <= 31));
            exp_bcd  = (c < 16) ? 16'h0000 : (c < 32) ? 16'h0056 : 16'h0789;
            chk($sformatf("retrig busy c%0d", c), 32'(busy), 32'(exp_busy));
            chk($sformatf("retrig bcd c%0d", c), 32'(bcd_out), 32'(exp_bcd));
            if (c == 5) bin_data = 14'd789;
        end
        chk("retrig ovf", 32'(ovf), 32'h0);

        // Reset asserted mid-SHIFT aborts at once; conversion reruns afterwards.
        bin_data = 14'd321;
        ticks(4);
        chk("pre-reset busy", 32'(busy), 32'h1);
        sys_rst_n = 1'b0;
        #1;
        check_reset_outputs("async reset");
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        ticks(15);
        chk("post-reset bcd N+15", 32'(bcd_out), 32'h0);
        chk("post-reset busy N+15", 32'(busy), 32'h1);
        tick();
        chk("post-reset bcd", 32'(bcd_out), 32'h0000_0321);
        chk("post-reset busy", 32'(busy), 32'h0);
        ticks(4 * P + 2);
        check_digits("post-reset", 8'hF9, 8'hA4, 8'hB0, 8'hFF);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
